// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle of the hazard controller's pipeline-side signals.
//               The controller connects through the slave modport. The
//               pipeline or a test driver connects through the master
//               modport.
//   Requests   : jump_req_i/jump_addr_i, ex_is_load_i, ex_rd_i, id_rs1_i,
//                id_rs2_i, id_use_rs1_i, id_use_rs2_i, mem_req_i,
//                mem_ack_i, div_start_i, div_done_i
//   Controls   : hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
//                flush_id_ex_o, jump_ena_o, jump_addr_o, bus_err_o,
//                stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              jump_req_i;
  logic [31:0]       jump_addr_i;
  logic              ex_is_load_i;
  logic [4:0]        ex_rd_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic              mem_req_i;
  logic              mem_ack_i;
  logic              div_start_i;
  logic              div_done_i;
  logic              hold_pc_o;
  logic              hold_if_id_o;
  logic              hold_id_ex_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic              jump_ena_o;
  logic [31:0]       jump_addr_o;
  logic              bus_err_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output jump_req_i, jump_addr_i, ex_is_load_i, ex_rd_i, id_rs1_i,
           id_rs2_i, id_use_rs1_i, id_use_rs2_i, mem_req_i, mem_ack_i,
           div_start_i, div_done_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
           flush_id_ex_o, jump_ena_o, jump_addr_o, bus_err_o, stall_cnt_o
  );

  modport slave (
    input  jump_req_i, jump_addr_i, ex_is_load_i, ex_rd_i, id_rs1_i,
           id_rs2_i, id_use_rs1_i, id_use_rs2_i, mem_req_i, mem_ack_i,
           div_start_i, div_done_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
           flush_id_ex_o, jump_ena_o, jump_addr_o, bus_err_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central hold/flush controller for the 5-stage core.
//               Resolves load-use hazards, EX redirects, divider waits and
//               data-bus wait states (with timeout). Counts stalled cycles.
//   clk_100MHz : core clock, rising edge
//   arst_n     : asynchronous active-low reset
//   hz         : pipe_hazard_ctrl_if slave modport (requests in, controls out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int             c_TW         = $clog2(BUS_TIMEOUT + 1);
  localparam logic [1:0]     c_ST_RUN     = 2'd0;
  localparam logic [1:0]     c_ST_BUS     = 2'd1;
  localparam logic [1:0]     c_ST_DIV     = 2'd2;
  // The entry cycle in RUN is stall cycle 1, so the register lags the
  // cycle count by one; release when this cycle would be cycle BUS_TIMEOUT.
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(BUS_TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_TCNT_ONE  = c_TW'(1);

  logic [1:0]       r_state,     w_state_nxt;
  logic [c_TW-1:0]  r_tcnt,      w_tcnt_nxt;
  logic             r_pend_vld,  w_pend_vld_nxt;
  logic [31:0]      r_pend_addr, w_pend_addr_nxt;
  logic             r_bus_err,   w_bus_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_bus_miss;
  logic             w_load_use;
  logic             w_tmo;
  logic             w_exit;
  logic [31:0]      w_exit_addr;

  logic w_hold_pc, w_hold_if_id, w_hold_id_ex;
  logic w_flush_if_id, w_flush_id_ex, w_jump_ena;
  logic [31:0] w_jump_addr;

  assign w_bus_miss = hz.mem_req_i & ~hz.mem_ack_i;
  assign w_load_use = hz.ex_is_load_i && (hz.ex_rd_i != 5'd0) &&
                      (((hz.ex_rd_i == hz.id_rs1_i) && hz.id_use_rs1_i) ||
                       ((hz.ex_rd_i == hz.id_rs2_i) && hz.id_use_rs2_i));
  assign w_tmo      = (r_tcnt == c_TMO_LAST);
  assign w_exit     = ((r_state == c_ST_BUS) && (hz.mem_ack_i || w_tmo)) ||
                      ((r_state == c_ST_DIV) && hz.div_done_i);
  // A request arriving in the exit cycle itself is the newest one.
  assign w_exit_addr = hz.jump_req_i ? hz.jump_addr_i : r_pend_addr;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= c_ST_RUN;
      r_tcnt      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_tcnt_nxt      = r_tcnt;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_bus_err_nxt   = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        if (w_bus_miss) begin
          w_state_nxt = c_ST_BUS;
          w_tcnt_nxt  = c_TCNT_ONE;
        end else if (hz.div_start_i) begin
          w_state_nxt = c_ST_DIV;
        end
        // A redirect that coincides with a wait entry must survive the wait.
        if ((w_bus_miss || hz.div_start_i) && hz.jump_req_i) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_addr_nxt = hz.jump_addr_i;
        end
      end
      c_ST_BUS, c_ST_DIV: begin
        if (w_exit) begin
          w_state_nxt     = c_ST_RUN;
          w_tcnt_nxt      = '0;
          w_pend_vld_nxt  = 1'b0;
          w_pend_addr_nxt = '0;
          w_bus_err_nxt   = (r_state == c_ST_BUS) && !hz.mem_ack_i;
        end else begin
          if (r_state == c_ST_BUS) begin
            w_tcnt_nxt = r_tcnt + c_TCNT_ONE;
          end
          if (hz.jump_req_i) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = hz.jump_addr_i;
          end
        end
      end
      default: begin
        w_state_nxt = c_ST_RUN;
        w_tcnt_nxt  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_hold_pc     = 1'b0;
    w_hold_if_id  = 1'b0;
    w_hold_id_ex  = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_jump_ena    = 1'b0;
    w_jump_addr   = '0;
    case (r_state)
      c_ST_RUN: begin
        if (w_bus_miss || hz.div_start_i) begin
          w_hold_pc    = 1'b1;
          w_hold_if_id = 1'b1;
          w_hold_id_ex = 1'b1;
        end else if (hz.jump_req_i) begin
          // Redirect takes priority, which also masks any load-use check.
          w_jump_ena    = 1'b1;
          w_jump_addr   = hz.jump_addr_i;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (w_load_use) begin
          w_hold_pc     = 1'b1;
          w_hold_if_id  = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      c_ST_BUS, c_ST_DIV: begin
        if (!w_exit) begin
          w_hold_pc    = 1'b1;
          w_hold_if_id = 1'b1;
          w_hold_id_ex = 1'b1;
        end else if (r_pend_vld || hz.jump_req_i) begin
          w_jump_ena    = 1'b1;
          w_jump_addr   = w_exit_addr;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      default: begin
        w_hold_pc = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall counter (saturating)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hold_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Controls are forced low while reset is held, even if requests are active.
  assign hz.hold_pc_o     = w_hold_pc     & arst_n;
  assign hz.hold_if_id_o  = w_hold_if_id  & arst_n;
  assign hz.hold_id_ex_o  = w_hold_id_ex  & arst_n;
  assign hz.flush_if_id_o = w_flush_if_id & arst_n;
  assign hz.flush_id_ex_o = w_flush_id_ex & arst_n;
  assign hz.jump_ena_o    = w_jump_ena    & arst_n;
  assign hz.jump_addr_o   = w_jump_addr   & {32{arst_n}};
  assign hz.bus_err_o     = r_bus_err;
  assign hz.stall_cnt_o   = r_stall_cnt;

endmodule
`default_nettype wire
